// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_pkg
// Description : Shared types and constants for the ADC frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 12;
    localparam int unsigned DEF_CAPTURE_TIMEOUT = 4;
    // Shortest legal frame-start spacing: frame, full capture window, one WAIT clock
    localparam int unsigned MIN_PERIOD          = DEF_DATA_WIDTH + DEF_CAPTURE_TIMEOUT + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FRAME   = 2'd1,
        S_CAPTURE = 2'd2,
        S_WAIT    = 2'd3
    } seq_state_e;

    // Minimum period for an arbitrary frame width / capture window
    function automatic int unsigned min_period(input int unsigned dw, input int unsigned to);
        return dw + to + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_reg.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_reg
// Description : One-entry valid/ready output register. A new sample always
//               overwrites the held one; losing an unconsumed sample raises
//               a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_reg
    import adc_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  ready_i,
    input  logic                  clr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  overrun_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic                  lost_d;

    // A sample is lost when it is still pending and not taken in the load cycle
    assign lost_d = load_i && valid_q && !ready_i;

    // Data/valid register: a fresh load takes priority over a consume
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= load_data_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky overrun flag: a set event in the clear cycle keeps it high
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (lost_d) begin
            overrun_q <= 1'b1;
        end else if (clr_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: rtl/adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_sequencer
// Description : Generates periodic DATA_WIDTH-clock chip-select frames for an
//               SPI receive master, captures one sample per frame into a
//               valid/ready output register and flags missing samples.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_sequencer
    import adc_seq_pkg::*;
#(
    parameter int DATA_WIDTH      = 12,
    parameter int PERIOD_WIDTH    = 16,
    parameter int CAPTURE_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    trigger_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic                    clr_status_i,
    output logic                    spi_ssel_o,
    input  logic [DATA_WIDTH-1:0]   spi_data_i,
    input  logic                    spi_valid_i,
    output logic [DATA_WIDTH-1:0]   m_data_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic                    frame_err_o
);

    localparam int unsigned c_MIN_PERIOD = min_period(DATA_WIDTH, CAPTURE_TIMEOUT);
    localparam int          c_CNT_W      = $clog2((DATA_WIDTH > CAPTURE_TIMEOUT) ? DATA_WIDTH
                                                                                 : CAPTURE_TIMEOUT);
    localparam logic [c_CNT_W-1:0]      c_BIT_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0]      c_CAP_LAST = c_CNT_W'(CAPTURE_TIMEOUT - 1);
    localparam logic [PERIOD_WIDTH-1:0] c_MIN_PER  = PERIOD_WIDTH'(c_MIN_PERIOD);

    seq_state_e              state_q, state_d;
    logic [c_CNT_W-1:0]      cnt_q, cnt_d;          // bit count in FRAME, wait count in CAPTURE
    logic [PERIOD_WIDTH-1:0] elapsed_q, elapsed_d;  // clocks since the current frame start
    logic [PERIOD_WIDTH-1:0] eff_period_q, eff_period_d;
    logic                    ssel_q;
    logic                    frame_err_q;
    logic                    load_d;
    logic                    err_set_d;
    logic                    frame_start_d;

    // Next-state logic; the counter restarts on every state change
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        load_d       = 1'b0;
        err_set_d    = 1'b0;
        elapsed_d    = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
        eff_period_d = eff_period_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i || trigger_i) state_d = S_FRAME;
            end
            S_FRAME: begin
                if (cnt_q == c_BIT_LAST) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // The release clock itself is inside the capture window
                if (spi_valid_i) begin
                    load_d  = 1'b1;
                    state_d = S_WAIT;
                end else if (cnt_q == c_CAP_LAST) begin
                    err_set_d = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (elapsed_q >= eff_period_q) begin
                    state_d = S_FRAME;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Period is sampled (and clamped) only when a frame starts
        frame_start_d = (state_d == S_FRAME) && (state_q != S_FRAME);
        if (frame_start_d) begin
            elapsed_d    = PERIOD_WIDTH'(1);
            eff_period_d = (period_i < c_MIN_PER) ? c_MIN_PER : period_i;
        end
    end

    // State, counters and the registered chip-select (low exactly in FRAME)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            elapsed_q    <= '0;
            eff_period_q <= '0;
            ssel_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            elapsed_q    <= elapsed_d;
            eff_period_q <= eff_period_d;
            ssel_q       <= (state_d != S_FRAME);
        end
    end

    // Sticky missing-sample flag: a set event in the clear cycle keeps it high
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else if (err_set_d) begin
            frame_err_q <= 1'b1;
        end else if (clr_status_i) begin
            frame_err_q <= 1'b0;
        end
    end

    adc_sample_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sample_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_d),
        .load_data_i (spi_data_i),
        .ready_i     (m_ready_i),
        .clr_i       (clr_status_i),
        .data_o      (m_data_o),
        .valid_o     (m_valid_o),
        .overrun_o   (overrun_o)
    );

    assign spi_ssel_o  = ssel_q;
    assign busy_o      = (state_q == S_FRAME) || (state_q == S_CAPTURE);
    assign frame_err_o = frame_err_q;

endmodule
`default_nettype wire

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Sequences the SPI receive master that captures serial ADC samples. Generates periodic chip-select frames of exactly DATA_WIDTH clocks and checks that each frame yields one sample_valid pulse. Forwards each sample on a valid/ready stream with a one-entry output register, and flags overruns and missing samples. Sits between the sample-rate configuration and the SPI master; drives the master's ssel_in and consumes its d_reg_master/sample_valid outputs.

Parameters:
DATA_WIDTH, 12, bits per ADC frame; must match the SPI master.
PERIOD_WIDTH, 16, width of the period input and the elapsed counter.
CAPTURE_TIMEOUT, 4, clocks allowed after ssel release for spi_valid to arrive.

Ports:
clk  input  1  system clock, also the SPI sck.
rst  input  1  synchronous active-high reset.
enable  input  1  continuous sampling when high.
trigger  input  1  one-cycle pulse; starts a single frame when enable=0 and state is IDLE.
period  input  PERIOD_WIDTH  clocks between frame starts; sampled at each frame start.
clr_status  input  1  clears the sticky overrun and frame_err flags.
spi_ssel  output  1  registered chip-select to the SPI master ssel_in, active-low.
spi_data  input  DATA_WIDTH  SPI master d_reg_master.
spi_valid  input  1  SPI master sample_valid.
m_data  output  DATA_WIDTH  captured sample.
m_valid  output  1  m_data holds an unconsumed sample.
m_ready  input  1  downstream accepts m_data.
busy  output  1  high in FRAME or CAPTURE.
overrun  output  1  sticky: a sample was overwritten before being consumed.
frame_err  output  1  sticky: a frame ended without spi_valid within the timeout.

Behaviour:
- Reset values: spi_ssel=1, m_data=0, m_valid=0, busy=0, overrun=0, frame_err=0; state=IDLE; all counters=0.
- The FSM has four states: IDLE, FRAME, CAPTURE and WAIT.
- IDLE: leave to FRAME when enable=1, or when trigger=1.
- FRAME: spi_ssel=0 for exactly DATA_WIDTH consecutive clocks. On entry, the bit counter clears and the elapsed counter loads 1. Leave to CAPTURE after the DATA_WIDTH-th low clock.
- CAPTURE: spi_ssel=1.
  - If spi_valid is seen within CAPTURE_TIMEOUT clocks, latch spi_data and go to WAIT.
  - Otherwise set frame_err and go to WAIT.
  - A spi_valid arriving in the same clock as ssel release is accepted.
- WAIT:
  - If enable=0, go to IDLE.
  - Else go to FRAME when elapsed >= eff_period.
  - eff_period = max(period, DATA_WIDTH+CAPTURE_TIMEOUT+1).
  - The elapsed counter increments every clock from frame start and saturates at all-ones.
- busy=1 exactly in FRAME and CAPTURE.
- Deasserting enable mid-frame does not truncate the frame: FRAME and CAPTURE complete, then the FSM returns to IDLE through WAIT.
- trigger is ignored outside IDLE and while enable=1.
- Output register:
  - Latched sample: m_data<=spi_data, m_valid<=1 on the next clock.
  - If m_valid=1 and m_ready=0 when a new sample latches, m_data is overwritten and overrun is set.
  - If m_ready=1 in the same cycle as a new latch, there is no overrun and m_valid stays 1 with the new data.
  - m_ready=1 with m_valid=1 and no new sample: m_valid<=0 next clock.
- Latency: m_valid rises 1 clock after spi_valid is accepted.
- clr_status clears both sticky flags. A set event in the same cycle wins (the flag stays 1).
- spi_valid outside CAPTURE is ignored, with no flag.
- rst at any time, including mid-frame, returns spi_ssel=1 on the next edge and loads all reset values.
- A period change takes effect at the next frame start only.

Decomposition:
- Shared package adc_seq_pkg holds the state enum (IDLE, FRAME, CAPTURE, WAIT) and constant MIN_PERIOD = DATA_WIDTH+CAPTURE_TIMEOUT+1.
- One natural sub-module: adc_sample_reg, the one-entry valid/ready output register with overrun detection.
- Everything else is in the top module.

Test Plan:
- Continuous capture: rst then enable=1, period=30, and a SPI-master model returning 0xA5C.
  - spi_ssel low 12 clocks per frame; frame starts 30 clocks apart.
  - m_data=0xA5C with m_valid one clock after spi_valid.
  - frame_err=0, overrun=0.
- Period clamp: period=5.
  - Frame starts are 17 clocks apart (12+4+1).
  - spi_ssel is never low for more or fewer than 12 clocks.
- Single shot: enable=0, one trigger pulse.
  - Exactly one 12-clock frame and one m_valid; then IDLE.
  - A second trigger during busy produces no extra frame.
- Overrun and clear:
  - m_ready held 0 over two frames → m_data holds the second sample and overrun=1.
  - clr_status pulse → overrun=0.
  - m_ready=1 in the latch cycle → no overrun.
- Missing sample: the model never pulses spi_valid → frame_err=1 after 4 CAPTURE clocks, and sequencing continues at the period.
- Mid-frame events:
  - enable dropped at low clock 5 → the frame completes all 12 low clocks and the sample is delivered, then IDLE.
  - rst at low clock 5 → spi_ssel=1 and m_valid=0 on the next edge.
